// File: rtl/ecg_layer_scheduler.sv
// Layer sequencer for the shared ECG CNN engine: launches each layer in turn, then
// reduces the streamed final-layer scores to an argmax class, guarded by a watchdog.
module ecg_layer_scheduler #(
  parameter int NUM_LAYERS = 5,
  parameter int NUM_CLASS  = 5,
  parameter int SCORE_W    = 16,
  parameter int TIMEOUT    = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic               busy_o,
  output logic [2:0]         layer_idx_o,
  output logic               eng_start_o,
  input  logic               eng_done_i,
  input  logic               score_valid_i,
  input  logic [SCORE_W-1:0] score_data_i,
  output logic [2:0]         class_o,
  output logic               class_valid_o,
  output logic               err_o
);

  localparam logic [2:0]  LAST_LAYER = 3'(NUM_LAYERS - 1);
  localparam logic [2:0]  LAST_CLASS = 3'(NUM_CLASS - 1);
  localparam logic [15:0] WD_LIMIT   = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    ARGMAX = 3'd3,
    OUT    = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [2:0]                layer_q, layer_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [2:0]                best_idx_q, best_idx_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  logic [2:0]                class_q, class_d;
  logic                      err_q, err_d;
  logic [15:0]               wd_q, wd_d;
  logic                      score_take;
  logic                      wd_expired;

  // Strictly-greater keeps the lower index on ties; the first score always wins.
  assign score_take = (cnt_q == 3'd0) || ($signed(score_data_i) > best_q);
  assign wd_expired = (wd_q == WD_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      layer_q    <= 3'd0;
      cnt_q      <= 3'd0;
      best_idx_q <= 3'd0;
      best_q     <= '0;
      class_q    <= 3'd0;
      err_q      <= 1'b0;
      wd_q       <= 16'd0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
      class_q    <= class_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    best_d     = best_q;
    class_d    = class_q;
    err_d      = err_q;
    wd_d       = wd_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          layer_d = 3'd0;
          err_d   = 1'b0;
          wd_d    = 16'd0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_d    = 16'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done_i) begin
          wd_d = 16'd0;
          if (layer_q == LAST_LAYER) begin
            cnt_d      = 3'd0;
            best_d     = '0;
            best_idx_d = 3'd0;
            state_d    = ARGMAX;
          end else begin
            layer_d = layer_q + 3'd1;
            state_d = LAUNCH;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      ARGMAX: begin
        if (score_valid_i) begin
          wd_d = 16'd0;
          if (score_take) begin
            best_d     = $signed(score_data_i);
            best_idx_d = cnt_q;
          end
          // The final score must be folded in directly; best_idx_q lags by one.
          if (cnt_q == LAST_CLASS) begin
            class_d = score_take ? cnt_q : best_idx_q;
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign eng_start_o   = (state_q == LAUNCH);
  assign class_valid_o = (state_q == OUT);
  assign layer_idx_o   = layer_q;
  assign class_o       = class_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ecg_layer_scheduler.sv
// Randomized bench for ecg_layer_scheduler: a cycle-level engine/score environment
// plus a plain-arithmetic reference for launch order, argmax, timing and timeouts.
module tb_ecg_layer_scheduler;

  localparam int NL = 5;
  localparam int NC = 5;
  localparam int SW = 16;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          busy_o;
  logic [2:0]    layer_idx_o;
  logic          eng_start_o;
  logic          eng_done_i;
  logic          score_valid_i;
  logic [SW-1:0] score_data_i;
  logic [2:0]    class_o;
  logic          class_valid_o;
  logic          err_o;

  always #5 clk = ~clk;

  ecg_layer_scheduler #(
    .NUM_LAYERS(NL), .NUM_CLASS(NC), .SCORE_W(SW), .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .layer_idx_o  (layer_idx_o),
    .eng_start_o  (eng_start_o),
    .eng_done_i   (eng_done_i),
    .score_valid_i(score_valid_i),
    .score_data_i (score_data_i),
    .class_o      (class_o),
    .class_valid_o(class_valid_o),
    .err_o        (err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus description for one inference.
  logic signed [SW-1:0] scores [8];
  int                   delays [8];   // cycles from eng_start to eng_done; 0 = never answer
  int                   gap;          // cycles between successive scores
  bit                   hold_start;
  bit                   noise;

  // Observations of the last inference (cycle 0 = the cycle start is driven).
  int         launch_q[$];
  int         launch_cyc_q[$];
  int         cv_count, cv_cycle, err_cycle;
  logic [2:0] cv_class;
  logic       busy_after;
  bit         aborted;
  logic [2:0] exp_class;

  function automatic int ref_argmax();
    logic signed [SW-1:0] top;
    top = scores[0];
    for (int i = 1; i < NC; i++) if (scores[i] > top) top = scores[i];
    for (int i = 0; i < NC; i++) if (scores[i] == top) return i;
    return 0;
  endfunction

  // Cycle of the first ARGMAX cycle: each layer costs one launch cycle plus its delay.
  function automatic int ref_argmax_cycle();
    int c;
    c = 1;
    for (int i = 0; i < NL; i++) c += delays[i] + 1;
    return c;
  endfunction

  function automatic int ref_out_cycle();
    return ref_argmax_cycle() + (NC - 1) * gap + 1;
  endfunction

  task automatic set_scores5(input int a, input int b, input int c, input int d, input int e);
    scores[0] = 16'(a); scores[1] = 16'(b); scores[2] = 16'(c);
    scores[3] = 16'(d); scores[4] = 16'(e);
  endtask

  task automatic set_delays(input int d);
    for (int i = 0; i < 8; i++) delays[i] = d;
  endtask

  task automatic rand_scores();
    int v;
    for (int i = 0; i < NC; i++) begin
      v = $urandom_range(0, 19);
      if (v == 0)      scores[i] = 16'sh7fff;
      else if (v == 1) scores[i] = 16'sh8000;
      else             scores[i] = 16'(v - 10);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Environment for one inference; must be called right after a negedge.
  task automatic run_inf(input int abort_layer);
    int timer, s_timer, s_idx;
    bit s_on, cv_seen, done, abort_next;
    launch_q.delete();
    launch_cyc_q.delete();
    cv_count = 0; cv_cycle = -1; cv_class = 3'd0; err_cycle = -1;
    busy_after = 1'b1; aborted = 1'b0;
    timer = 0; s_timer = 0; s_idx = 0;
    s_on = 1'b0; cv_seen = 1'b0; done = 1'b0; abort_next = 1'b0;
    start_i = 1'b1;
    for (int cyc = 1; cyc <= 800 && !done; cyc++) begin
      @(negedge clk);
      if (abort_next) begin
        rst_n = 1'b0;
        aborted = 1'b1;
        done = 1'b1;
      end else if (cv_seen) begin
        busy_after = busy_o;
        done = 1'b1;
      end else if (err_o) begin
        err_cycle = cyc;
        busy_after = busy_o;
        done = 1'b1;
      end else begin
        if (!hold_start) start_i = 1'b0;
        eng_done_i = 1'b0;
        score_valid_i = 1'b0;
        score_data_i = 16'($urandom);
        if (class_valid_o) begin
          cv_count++;
          cv_cycle = cyc;
          cv_class = class_o;
          cv_seen = 1'b1;
          start_i = 1'b0;
        end
        if (s_on) begin
          s_timer--;
          if (s_timer == 0) begin
            score_valid_i = 1'b1;
            score_data_i = scores[s_idx];
            s_idx++;
            if (s_idx == NC) s_on = 1'b0;
            else s_timer = gap;
          end
        end else if (noise && s_idx == 0) begin
          score_valid_i = 1'($urandom_range(0, 1));
        end
        if (timer > 0) begin
          timer--;
          if (timer == 0) begin
            eng_done_i = 1'b1;
            if (launch_q[$] == NL - 1) begin
              s_on = 1'b1;
              s_timer = 1;
            end
          end
        end
        if (eng_start_o) begin
          launch_q.push_back(int'(layer_idx_o));
          launch_cyc_q.push_back(cyc);
          timer = delays[layer_idx_o];
          if (noise) eng_done_i = 1'b1;
          if (int'(layer_idx_o) == abort_layer) abort_next = 1'b1;
        end
      end
    end
    start_i = 1'b0;
    eng_done_i = 1'b0;
    score_valid_i = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL run_budget: inference got no class_valid/err within 800 cycles, required one");
    end
    $display("inference: launches=%0d class_valid=%0d class=%0d cv_cycle=%0d err_cycle=%0d aborted=%0d",
             launch_q.size(), cv_count, cv_class, cv_cycle, err_cycle, aborted);
  endtask

  task automatic test_reset();
    n_cmp += 6;
    if (busy_o !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    if (eng_start_o !== 1'b0)   begin n_bad++; $display("FAIL reset_eng_start: got %b want 0", eng_start_o); end
    if (layer_idx_o !== 3'd0)   begin n_bad++; $display("FAIL reset_layer: got %0d want 0", layer_idx_o); end
    if (class_o !== 3'd0)       begin n_bad++; $display("FAIL reset_class: got %0d want 0", class_o); end
    if (class_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_class_valid: got %b want 0", class_valid_o); end
    if (err_o !== 1'b0)         begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    rst_n = 1'b1;
    idle(2);
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy_o); end
    exp_class = 3'd0;
  endtask

  task automatic test_nominal();
    hold_start = 0; noise = 0; gap = 1;
    set_delays(3);
    set_scores5(10, -4, 37, 37, 2);
    run_inf(-1);
    n_cmp += 6;
    if (launch_q.size() !== NL) begin n_bad++; $display("FAIL nominal_launches: got %0d want %0d", launch_q.size(), NL); end
    for (int i = 0; i < launch_q.size(); i++) begin
      n_cmp++;
      if (launch_q[i] !== i) begin n_bad++; $display("FAIL nominal_layer%0d: got %0d want %0d", i, launch_q[i], i); end
    end
    if (launch_q.size() > 0 && launch_cyc_q[0] !== 1) begin n_bad++; $display("FAIL nominal_first_launch: got cycle %0d want 1", launch_cyc_q[0]); end
    if (cv_count !== 1)        begin n_bad++; $display("FAIL nominal_cv_count: got %0d want 1", cv_count); end
    if (cv_class !== 3'd2)     begin n_bad++; $display("FAIL nominal_class: got %0d want 2", cv_class); end
    if (cv_cycle !== ref_out_cycle()) begin n_bad++; $display("FAIL nominal_cv_cycle: got %0d want %0d", cv_cycle, ref_out_cycle()); end
    if (busy_after !== 1'b0)   begin n_bad++; $display("FAIL nominal_busy_fall: got %b want 0", busy_after); end
    exp_class = 3'd2;
    idle(2);
  endtask

  task automatic test_ties();
    hold_start = 0; noise = 0; gap = 1;
    set_delays(1);
    set_scores5(-100, -50, -50, -200, -60);
    run_inf(-1);
    n_cmp += 2;
    if (cv_class !== 3'd1) begin n_bad++; $display("FAIL ties_signed: got %0d want 1", cv_class); end
    if (cv_cycle !== 2 * NL + NC + 1) begin n_bad++; $display("FAIL ties_min_latency: got %0d want %0d", cv_cycle, 2 * NL + NC + 1); end
    idle(1);
    for (int i = 0; i < NC; i++) scores[i] = 16'sh0123;
    run_inf(-1);
    n_cmp++;
    if (cv_class !== 3'd0) begin n_bad++; $display("FAIL ties_all_equal: got %0d want 0", cv_class); end
    exp_class = 3'd0;
    idle(2);
  endtask

  task automatic test_noise();
    hold_start = 1; noise = 1; gap = 1;
    set_delays(3);
    set_scores5(10, -4, 37, 37, 2);
    eng_done_i = 1'b1;
    idle(3);
    eng_done_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL noise_idle_done: busy got %b want 0", busy_o); end
    run_inf(-1);
    n_cmp += 4;
    if (launch_q.size() !== NL) begin n_bad++; $display("FAIL noise_launches: got %0d want %0d", launch_q.size(), NL); end
    if (cv_count !== 1)         begin n_bad++; $display("FAIL noise_cv_count: got %0d want 1", cv_count); end
    if (cv_class !== 3'd2)      begin n_bad++; $display("FAIL noise_class: got %0d want 2", cv_class); end
    if (cv_cycle !== ref_out_cycle()) begin n_bad++; $display("FAIL noise_cv_cycle: got %0d want %0d", cv_cycle, ref_out_cycle()); end
    for (int i = 0; i < launch_q.size(); i++) begin
      n_cmp++;
      if (launch_q[i] !== i) begin n_bad++; $display("FAIL noise_layer%0d: got %0d want %0d", i, launch_q[i], i); end
    end
    exp_class = 3'd2;
    hold_start = 0; noise = 0;
    idle(2);
  endtask

  task automatic test_timeout();
    int want;
    hold_start = 0; noise = 0; gap = 1;
    set_delays(3);
    delays[1] = 2;
    delays[2] = 0;
    rand_scores();
    run_inf(-1);
    n_cmp += 5;
    if (launch_q.size() !== 3) begin n_bad++; $display("FAIL timeout_launches: got %0d want 3", launch_q.size()); end
    want = (launch_q.size() == 3) ? launch_cyc_q[2] + TO + 1 : -2;
    if (err_cycle !== want)    begin n_bad++; $display("FAIL timeout_err_cycle: got %0d want %0d", err_cycle, want); end
    if (busy_after !== 1'b0)   begin n_bad++; $display("FAIL timeout_busy: got %b want 0", busy_after); end
    if (cv_count !== 0)        begin n_bad++; $display("FAIL timeout_cv_count: got %0d want 0", cv_count); end
    if (class_o !== exp_class) begin n_bad++; $display("FAIL timeout_class_kept: got %0d want %0d", class_o, exp_class); end
    idle(3);
    n_cmp++;
    if (err_o !== 1'b1) begin n_bad++; $display("FAIL timeout_err_sticky: got %b want 1", err_o); end
    // Done on the last watchdog cycle and scores exactly TO apart both just make it.
    set_delays(2);
    delays[0] = TO;
    gap = TO;
    rand_scores();
    run_inf(-1);
    n_cmp += 3;
    if (err_cycle !== -1) begin n_bad++; $display("FAIL timeout_edge_err: err seen at cycle %0d want none", err_cycle); end
    if (cv_class !== 3'(ref_argmax())) begin n_bad++; $display("FAIL timeout_edge_class: got %0d want %0d", cv_class, ref_argmax()); end
    if (err_o !== 1'b0)   begin n_bad++; $display("FAIL timeout_err_cleared: got %b want 0", err_o); end
    exp_class = 3'(ref_argmax());
    idle(2);
    gap = TO + 1;
    rand_scores();
    run_inf(-1);
    want = ref_argmax_cycle() + TO + 1;
    n_cmp += 3;
    if (err_cycle !== want) begin n_bad++; $display("FAIL timeout_argmax_err: got %0d want %0d", err_cycle, want); end
    if (cv_count !== 0)     begin n_bad++; $display("FAIL timeout_argmax_cv: got %0d want 0", cv_count); end
    if (class_o !== exp_class) begin n_bad++; $display("FAIL timeout_argmax_class: got %0d want %0d", class_o, exp_class); end
    idle(2);
  endtask

  task automatic test_gapped();
    hold_start = 0; noise = 1; gap = 4;
    for (int i = 0; i < 8; i++) delays[i] = $urandom_range(1, 8);
    rand_scores();
    run_inf(-1);
    n_cmp += 4;
    if (cv_count !== 1)  begin n_bad++; $display("FAIL gapped_cv_count: got %0d want 1", cv_count); end
    if (cv_class !== 3'(ref_argmax())) begin n_bad++; $display("FAIL gapped_class: got %0d want %0d", cv_class, ref_argmax()); end
    if (cv_cycle !== ref_out_cycle()) begin n_bad++; $display("FAIL gapped_cv_cycle: got %0d want %0d", cv_cycle, ref_out_cycle()); end
    if (err_cycle !== -1) begin n_bad++; $display("FAIL gapped_err: err at cycle %0d want none", err_cycle); end
    exp_class = 3'(ref_argmax());
    noise = 0;
    idle(2);
  endtask

  task automatic test_back_to_back();
    hold_start = 0; noise = 0; gap = 1;
    set_delays(1);
    rand_scores();
    run_inf(-1);
    n_cmp++;
    if (cv_class !== 3'(ref_argmax())) begin n_bad++; $display("FAIL b2b_first_class: got %0d want %0d", cv_class, ref_argmax()); end
    rand_scores();
    run_inf(-1);
    n_cmp += 3;
    if (launch_q.size() !== NL) begin n_bad++; $display("FAIL b2b_launches: got %0d want %0d", launch_q.size(), NL); end
    if (launch_q.size() > 0 && launch_cyc_q[0] !== 1) begin n_bad++; $display("FAIL b2b_accept: first launch cycle %0d want 1", launch_cyc_q[0]); end
    if (cv_class !== 3'(ref_argmax())) begin n_bad++; $display("FAIL b2b_second_class: got %0d want %0d", cv_class, ref_argmax()); end
    exp_class = 3'(ref_argmax());
    idle(2);
  endtask

  task automatic test_random();
    hold_start = 0; noise = 0;
    for (int t = 0; t < 8; t++) begin
      gap = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) delays[i] = $urandom_range(1, TO);
      rand_scores();
      run_inf(-1);
      n_cmp += 3;
      if (launch_q.size() !== NL) begin n_bad++; $display("FAIL random%0d_launches: got %0d want %0d", t, launch_q.size(), NL); end
      if (cv_class !== 3'(ref_argmax())) begin n_bad++; $display("FAIL random%0d_class: got %0d want %0d", t, cv_class, ref_argmax()); end
      if (cv_cycle !== ref_out_cycle()) begin n_bad++; $display("FAIL random%0d_cv_cycle: got %0d want %0d", t, cv_cycle, ref_out_cycle()); end
      exp_class = 3'(ref_argmax());
      idle($urandom_range(0, 3));
    end
    idle(1);
  endtask

  task automatic test_async_reset();
    hold_start = 0; noise = 0; gap = 1;
    set_delays(6);
    rand_scores();
    run_inf(3);
    #1;
    n_cmp += 7;
    if (launch_q.size() !== 4)  begin n_bad++; $display("FAIL areset_launches: got %0d want 4", launch_q.size()); end
    if (busy_o !== 1'b0)        begin n_bad++; $display("FAIL areset_busy: got %b want 0", busy_o); end
    if (eng_start_o !== 1'b0)   begin n_bad++; $display("FAIL areset_eng_start: got %b want 0", eng_start_o); end
    if (layer_idx_o !== 3'd0)   begin n_bad++; $display("FAIL areset_layer: got %0d want 0", layer_idx_o); end
    if (class_o !== 3'd0)       begin n_bad++; $display("FAIL areset_class: got %0d want 0", class_o); end
    if (class_valid_o !== 1'b0) begin n_bad++; $display("FAIL areset_class_valid: got %b want 0", class_valid_o); end
    if (err_o !== 1'b0)         begin n_bad++; $display("FAIL areset_err: got %b want 0", err_o); end
    exp_class = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    set_delays(2);
    rand_scores();
    run_inf(-1);
    n_cmp += 3;
    if (launch_q.size() !== NL) begin n_bad++; $display("FAIL areset_restart_launches: got %0d want %0d", launch_q.size(), NL); end
    if (launch_q.size() > 0 && launch_q[0] !== 0) begin n_bad++; $display("FAIL areset_restart_layer0: got %0d want 0", launch_q[0]); end
    if (cv_class !== 3'(ref_argmax())) begin n_bad++; $display("FAIL areset_restart_class: got %0d want %0d", cv_class, ref_argmax()); end
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    eng_done_i = 1'b0;
    score_valid_i = 1'b0;
    score_data_i = '0;
    hold_start = 0;
    noise = 0;
    gap = 1;
    set_delays(1);
    for (int i = 0; i < 8; i++) scores[i] = '0;
    idle(3);
    test_reset();
    test_nominal();
    test_ties();
    test_noise();
    test_timeout();
    test_gapped();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
